// File: rtl/main_memory_interface.sv
// rtl/main_memory_interface.sv - cache line fill/writeback engine toward a word-wide main memory
// Splits one line request into CACHE_WORDS word transfers, then holds MEM_RESP until the cache drops its request.
module main_memory_interface #(
   parameter int DATA_WIDTH        = 32,
   parameter int ADDRESS_BITS      = 32,
   parameter int CACHE_OFFSET_BITS = 2,
   parameter int MSG_BITS          = 4,
   localparam int CACHE_WORDS      = 1 << CACHE_OFFSET_BITS,
   localparam int CACHE_WIDTH      = DATA_WIDTH * CACHE_WORDS
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [MSG_BITS-1:0]     cache2mem_msg,
   input  logic [ADDRESS_BITS-1:0] cache2mem_address,
   input  logic [CACHE_WIDTH-1:0]  cache2mem_data,
   output logic [MSG_BITS-1:0]     mem2cache_msg,
   output logic [ADDRESS_BITS-1:0] mem2cache_address,
   output logic [CACHE_WIDTH-1:0]  mem2cache_data,
   output logic                    mem_intf_busy,
   output logic [ADDRESS_BITS-1:0] mem_intf_address,
   output logic                    mem_intf_address_valid,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_write_data,
   input  logic [DATA_WIDTH-1:0]   mem_read_data,
   input  logic                    mem_ready
);

   localparam logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0);
   localparam logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(1);
   localparam logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(2);
   localparam logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(8);

   typedef enum logic [1:0] {IDLE, READ_LINE, WRITE_LINE, RESPOND} state_t;

   state_t                       state_q;
   logic [CACHE_OFFSET_BITS-1:0] count_q;
   logic [ADDRESS_BITS-1:0]      base_q;
   logic [CACHE_WIDTH-1:0]       buffer_q;
   logic [MSG_BITS-1:0]          msg_q;
   logic [ADDRESS_BITS-1:0]      resp_addr_q;
   logic [CACHE_WIDTH-1:0]       resp_data_q;
   logic                         busy_q;
   logic                         mem_read_q;
   logic                         mem_write_q;
   logic [ADDRESS_BITS-1:0]      mem_addr_q;
   logic [DATA_WIDTH-1:0]        mem_wdata_q;

   logic [CACHE_WIDTH-1:0]       fill_line;
   logic [CACHE_OFFSET_BITS-1:0] next_count;
   logic                         last_word;
   logic [ADDRESS_BITS-1:0]      req_base;

   // Line buffer with the word currently returned from memory merged in.
   always_comb begin
      fill_line = buffer_q;
      fill_line[count_q*DATA_WIDTH +: DATA_WIDTH] = mem_read_data;
   end

   assign next_count = count_q + 1'b1;
   assign last_word  = (count_q == CACHE_OFFSET_BITS'(CACHE_WORDS - 1));
   assign req_base   = cache2mem_address & ~ADDRESS_BITS'(CACHE_WORDS - 1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         base_q      <= '0;
         buffer_q    <= '0;
         msg_q       <= NO_REQ;
         resp_addr_q <= '0;
         resp_data_q <= '0;
         busy_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cache2mem_msg == R_REQ || cache2mem_msg == WB_REQ) begin
                  base_q     <= req_base;
                  count_q    <= '0;
                  busy_q     <= 1'b1;
                  mem_addr_q <= req_base;
                  if (cache2mem_msg == R_REQ) begin
                     state_q    <= READ_LINE;
                     mem_read_q <= 1'b1;
                  end else begin
                     state_q     <= WRITE_LINE;
                     mem_write_q <= 1'b1;
                     buffer_q    <= cache2mem_data;
                     mem_wdata_q <= cache2mem_data[DATA_WIDTH-1:0];
                  end
               end
            end
            READ_LINE, WRITE_LINE: begin
               if (mem_ready) begin
                  if (state_q == READ_LINE) buffer_q <= fill_line;
                  if (last_word) begin
                     state_q     <= RESPOND;
                     mem_read_q  <= 1'b0;
                     mem_write_q <= 1'b0;
                     msg_q       <= MEM_RESP;
                     resp_addr_q <= base_q;
                     resp_data_q <= (state_q == READ_LINE) ? fill_line : buffer_q;
                  end else begin
                     count_q     <= next_count;
                     mem_addr_q  <= base_q | ADDRESS_BITS'(next_count);
                     mem_wdata_q <= buffer_q[next_count*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
            RESPOND: begin
               if (cache2mem_msg == NO_REQ) begin
                  state_q <= IDLE;
                  msg_q   <= NO_REQ;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem2cache_msg          = msg_q;
   assign mem2cache_address      = resp_addr_q;
   assign mem2cache_data         = resp_data_q;
   assign mem_intf_busy          = busy_q;
   assign mem_intf_address       = base_q;
   assign mem_intf_address_valid = busy_q;
   assign mem_read               = mem_read_q;
   assign mem_write              = mem_write_q;
   assign mem_address            = mem_addr_q;
   assign mem_write_data         = mem_wdata_q;

endmodule

// File: tb/tb_main_memory_interface.sv
// tb/tb_main_memory_interface.sv - scoreboard bench for main_memory_interface
// Driver queues expected word accesses and responses; a negedge monitor pops and compares them.
module tb_main_memory_interface;

   localparam logic [3:0] NO_REQ   = 4'd0;
   localparam logic [3:0] R_REQ    = 4'd1;
   localparam logic [3:0] WB_REQ   = 4'd2;
   localparam logic [3:0] MEM_RESP = 4'd8;

   logic         clock;
   logic         reset;
   logic [3:0]   cache2mem_msg;
   logic [31:0]  cache2mem_address;
   logic [127:0] cache2mem_data;
   logic [3:0]   mem2cache_msg;
   logic [31:0]  mem2cache_address;
   logic [127:0] mem2cache_data;
   logic         mem_intf_busy;
   logic [31:0]  mem_intf_address;
   logic         mem_intf_address_valid;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [31:0]  mem_write_data;
   logic [31:0]  mem_read_data;
   logic         mem_ready = 1'b1;

   main_memory_interface dut (
      .clock                  (clock),
      .reset                  (reset),
      .cache2mem_msg          (cache2mem_msg),
      .cache2mem_address      (cache2mem_address),
      .cache2mem_data         (cache2mem_data),
      .mem2cache_msg          (mem2cache_msg),
      .mem2cache_address      (mem2cache_address),
      .mem2cache_data         (mem2cache_data),
      .mem_intf_busy          (mem_intf_busy),
      .mem_intf_address       (mem_intf_address),
      .mem_intf_address_valid (mem_intf_address_valid),
      .mem_read               (mem_read),
      .mem_write              (mem_write),
      .mem_address            (mem_address),
      .mem_write_data         (mem_write_data),
      .mem_read_data          (mem_read_data),
      .mem_ready              (mem_ready)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
   } rsp_t;

   acc_t        acc_q[$];
   rsp_t        rsp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        rand_mode = 1'b0;
   logic [31:0] mem_arr [0:255];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      for (int k = 0; k < 256; k++) mem_arr[k] = 32'h100 + k;
   end

   assign mem_read_data = mem_arr[mem_address[7:0]];

   always @(posedge clock) begin
      if (reset && mem_write && mem_ready) mem_arr[mem_address[7:0]] <= mem_write_data;
   end

   always @(posedge clock) begin
      #2;
      mem_ready = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
   end

   task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask

   logic         prev_pending = 1'b0;
   logic [65:0]  prev_req;
   logic         prev_resp = 1'b0;
   logic [159:0] prev_resp_vec;

   always @(negedge clock) begin
      if (!reset) begin
         prev_pending = 1'b0;
         prev_resp    = 1'b0;
      end else begin
         if (prev_pending)
            chk("req_stable", {mem_read, mem_write, mem_address, mem_write_data}, prev_req);
         if ((mem_read || mem_write) && mem_ready) begin
            if (acc_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_access got addr %h want none", mem_address);
            end else begin
               acc_t e;
               e = acc_q.pop_front();
               chk("acc_kind", {mem_read, mem_write}, {~e.we, e.we});
               chk("acc_addr", mem_address, e.addr);
               if (e.we) chk("acc_wdata", mem_write_data, e.data);
            end
         end
         prev_pending = (mem_read || mem_write) && !mem_ready;
         prev_req     = {mem_read, mem_write, mem_address, mem_write_data};
         if (mem2cache_msg == MEM_RESP) begin
            if (prev_resp) begin
               chk("resp_stable", {mem2cache_address, mem2cache_data}, prev_resp_vec);
            end else if (rsp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp got addr %h want none", mem2cache_address);
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("resp_addr", mem2cache_address, r.addr);
               chk("resp_data", mem2cache_data, r.data);
            end
         end
         prev_resp     = (mem2cache_msg == MEM_RESP);
         prev_resp_vec = {mem2cache_address, mem2cache_data};
      end
   end

   task automatic run_req(input logic [3:0] msg, input logic [31:0] addr, input logic [127:0] line,
                          input logic [31:0] exp_base, input logic [127:0] exp_line,
                          input int hold, input int exp_lat);
      int cyc;
      for (int i = 0; i < 4; i++)
         acc_q.push_back('{we: (msg == WB_REQ), addr: exp_base + i, data: exp_line[i*32 +: 32]});
      rsp_q.push_back('{addr: exp_base, data: exp_line});
      cache2mem_msg     = msg;
      cache2mem_address = addr;
      cache2mem_data    = line;
      @(posedge clock); #1;
      chk("busy_after_accept", {mem_intf_busy, mem_intf_address_valid, mem_intf_address},
          {1'b1, 1'b1, exp_base});
      cache2mem_address = addr ^ 32'h40;
      cache2mem_data    = ~line;
      cyc = 1;
      while (mem2cache_msg !== MEM_RESP && cyc < 300) begin
         @(posedge clock); #1;
         cyc++;
      end
      chk("resp_seen", mem2cache_msg, MEM_RESP);
      if (exp_lat > 0) chk("latency", cyc, exp_lat);
      chk("resp_no_mem_req", {mem_read, mem_write}, 2'b00);
      for (int i = 1; i < hold; i++) begin
         @(posedge clock); #1;
         chk("resp_hold", {mem2cache_msg, mem_intf_busy}, {MEM_RESP, 1'b1});
      end
      cache2mem_msg = NO_REQ;
      @(posedge clock); #1;
      chk("idle_after_noreq", {mem2cache_msg, mem_intf_busy, mem_intf_address_valid},
          {NO_REQ, 1'b0, 1'b0});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_msg"}, mem2cache_msg, NO_REQ);
      chk({tag, "_resp_addr"}, mem2cache_address, 32'h0);
      chk({tag, "_resp_data"}, mem2cache_data, 128'h0);
      chk({tag, "_flags"}, {mem_intf_busy, mem_intf_address_valid, mem_read, mem_write}, 4'b0000);
      chk({tag, "_intf_addr"}, mem_intf_address, 32'h0);
      chk({tag, "_mem_addr"}, {mem_address, mem_write_data}, 64'h0);
   endtask

   logic [3:0] bad_codes [3];

   initial begin
      reset             = 1'b0;
      cache2mem_msg     = NO_REQ;
      cache2mem_address = 32'h0;
      cache2mem_data    = 128'h0;
      bad_codes         = '{4'hF, 4'h3, 4'h8};
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      reset = 1'b1;
      @(posedge clock); #1;

      run_req(R_REQ, 32'h13, 128'h0, 32'h10,
              128'h00000113_00000112_00000111_00000110, 1, 5);
      run_req(WB_REQ, 32'h20, 128'h0000000D_0000000C_0000000B_0000000A, 32'h20,
              128'h0000000D_0000000C_0000000B_0000000A, 1, 5);
      run_req(R_REQ, 32'h21, 128'h0, 32'h20,
              128'h0000000D_0000000C_0000000B_0000000A, 5, 5);

      for (int c = 0; c < 3; c++) begin
         cache2mem_msg = bad_codes[c];
         repeat (3) begin
            @(posedge clock); #1;
            chk("bad_code_ignored", {mem_intf_busy, mem_read, mem_write, mem2cache_msg},
                {1'b0, 1'b0, 1'b0, NO_REQ});
         end
      end
      cache2mem_msg = NO_REQ;
      @(posedge clock); #1;

      rand_mode = 1'b1;
      run_req(R_REQ, 32'h13, 128'h0, 32'h10,
              128'h00000113_00000112_00000111_00000110, 2, 0);
      run_req(WB_REQ, 32'h32, 128'h44444444_33333333_22222222_11111111, 32'h30,
              128'h44444444_33333333_22222222_11111111, 1, 0);
      run_req(R_REQ, 32'h30, 128'h0, 32'h30,
              128'h44444444_33333333_22222222_11111111, 1, 0);
      rand_mode = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      acc_q.push_back('{we: 1'b0, addr: 32'h40, data: 32'h0});
      acc_q.push_back('{we: 1'b0, addr: 32'h41, data: 32'h0});
      cache2mem_msg     = R_REQ;
      cache2mem_address = 32'h41;
      repeat (3) begin
         @(posedge clock); #1;
      end
      chk("word2_presented", {mem_read, mem_address}, {1'b1, 32'h42});
      reset         = 1'b0;
      cache2mem_msg = NO_REQ;
      #1;
      check_reset_outputs("midreset");
      @(posedge clock); #1;
      check_reset_outputs("midreset_hold");
      reset = 1'b1;
      @(posedge clock); #1;
      run_req(R_REQ, 32'h42, 128'h0, 32'h40,
              128'h00000143_00000142_00000141_00000140, 1, 5);

      repeat (3) @(posedge clock);
      #1;
      chk("acc_q_empty", acc_q.size(), 0);
      chk("rsp_q_empty", rsp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
